axi2wb_bridge: RTL and testbench
================================

// Module: axi2wb_bridge
// PURPOSE
//  AXI4-Lite slave to Wishbone classic master bridge; the inverse of wb2axi. Lets an AXI-Lite
//  initiator (e.g. an accelerator DMA port) issue single reads/writes onto the user-area Wishbone
//  bus, for example the exmem_fir window at 0x3800_0000. One transaction outstanding at a time.
//  Includes read/write arbitration and an ack timeout so a dead slave cannot hang the AXI side.
// PARAMETERS
//  ADDR_W   32    address width, AXI and Wishbone
//  DATA_W   32    data width; STRB_W = DATA_W/8
//  TIMEOUT  255   cycles to wait for wbm_ack_i before aborting with SLVERR (1..65535)
// PORTS
//  wb_clk_i       in   1        sole clock
//  wb_rst_i       in   1        synchronous reset, active-high
//  s_awaddr       in   ADDR_W   write address
//  s_awvalid      in   1        / s_awready out 1
//  s_wdata        in   DATA_W   write data
//  s_wstrb        in   STRB_W   byte strobes -> wbm_sel_o
//  s_wvalid       in   1        / s_wready out 1
//  s_bresp        out  2        00 OKAY, 10 SLVERR
//  s_bvalid       out  1        / s_bready in 1
//  s_araddr       in   ADDR_W   read address
//  s_arvalid      in   1        / s_arready out 1
//  s_rdata        out  DATA_W   read data
//  s_rresp        out  2        00 OKAY, 10 SLVERR
//  s_rvalid       out  1        / s_rready in 1
//  wbm_cyc_o/stb_o out 1        bus cycle / strobe, always asserted together
//  wbm_we_o       out  1        1 = write
//  wbm_adr_o      out  ADDR_W   address, passed unmodified
//  wbm_sel_o      out  STRB_W   byte select
//  wbm_dat_o      out  DATA_W   write data
//  wbm_dat_i      in   DATA_W   read data, sampled on ack
//  wbm_ack_i      in   1        slave acknowledge
// BEHAVIOUR
//  Reset: all *ready, *valid, wbm_cyc_o/stb_o/we_o = 0; resp = 00; data/adr/sel regs = 0;
//   holding-valid flags, timeout counter, rr flag cleared; state IDLE. Reset mid-transaction
//   aborts immediately: cyc drops next edge, no AXI response is issued for the aborted access.
//  Capture: s_awready = IDLE & !aw_q; s_wready = IDLE & !w_q; s_arready = IDLE & !ar_q.
//   AW and W accepted independently, any order or same cycle; each held until consumed.
//  States: IDLE, WB_WR, WB_RD, B_RESP, R_RESP.
//  IDLE: write eligible when aw_q & w_q; read eligible when ar_q. Both eligible -> rr flag picks
//   (rr=0 write first); rr toggles to favour the other side after each served access.
//   Write with s_wstrb==0 -> no bus cycle, go B_RESP with OKAY. Else drive wbm_* from holding
//   regs, cyc=stb=1 on the edge leaving IDLE -> WB_WR / WB_RD. Decision takes 1 cycle after capture.
//  WB_WR/WB_RD: outputs stable; counter increments each cycle. ack sampled high -> cyc/stb drop
//   next edge, resp OKAY, read latches wbm_dat_i into s_rdata. Counter reaches TIMEOUT without ack
//   -> cyc/stb drop, resp SLVERR, s_rdata = 0. Ack on the same cycle as timeout wins (OKAY).
//   Ack while cyc=0 is ignored.
//  B_RESP: s_bvalid=1 held until s_bready; then clear aw_q,w_q -> IDLE. R_RESP likewise with
//   s_rvalid/s_rready, clears ar_q. Backpressure is unbounded; no new capture while responding.
//  Latency: ack in cycle N -> bvalid/rvalid high from N+1. Min write (AW+W same cycle, ack on
//   first cyc cycle): capture c0, cyc c1, ack c1, bvalid c2.
//  Flags/counter: counter 16b, cleared on entering WB_*; no wrap since TIMEOUT <= 65535.
// TESTING
//  1. AW 0x3800_0010 + W 0xDEADBEEF strb F same cycle, slave acks 3rd cyc cycle -> one WB write,
//     adr/dat/sel exact, bresp 00, bvalid 1 cycle after ack.
//  2. AR 0x3010_0004, slave returns 0x1234_5678 with ack -> rdata 0x12345678, rresp 00; rready
//     held low 5 cycles -> rvalid/rdata stable, no new arready.
//  3. W arrives 4 cycles before AW; wstrb 0x0 case -> bresp 00, wbm_cyc_o never asserted.
//  4. AW+W and AR pending together, repeated 4 times -> WB order W,R,W,R (rr alternation).
//  5. TIMEOUT=8, no ack -> cyc high exactly 8 cycles, rresp 10, rdata 0; ack on cycle 8 -> OKAY.
//  6. wb_rst_i pulsed during WB_RD -> cyc 0 next edge, no rvalid, all readies 0 then IDLE.

Source files
------------

// File: rtl/axi2wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge, one access in flight at a time.
// AW/W/AR are held in capture registers until served; a stuck slave is aborted with SLVERR.
module axi2wb_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [STRB_W-1:0] s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [STRB_W-1:0] wbm_sel_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WB_WR  = 3'd1,
        ST_WB_RD  = 3'd2,
        ST_B_RESP = 3'd3,
        ST_R_RESP = 3'd4
    } state_t;

    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    state_t              r_state;
    logic                r_aw_q, r_w_q, r_ar_q, r_rr;
    logic [ADDR_W-1:0]   r_awaddr, r_araddr, r_adr;
    logic [DATA_W-1:0]   r_wdata, r_dat, r_rdata;
    logic [STRB_W-1:0]   r_wstrb, r_sel;
    logic [15:0]         r_cnt;
    logic                r_awready, r_wready, r_arready;
    logic                r_bvalid, r_rvalid, r_cyc, r_we;
    logic [1:0]          r_bresp, r_rresp;

    logic                w_aw_hs, w_w_hs, w_ar_hs;
    logic                w_aw_v, w_w_v, w_ar_v;
    logic                w_pick_wr, w_pick_rd;
    logic [ADDR_W-1:0]   w_awaddr, w_araddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [STRB_W-1:0]   w_wstrb;
    logic                w_done;
    logic [1:0]          w_resp;

    // A handshake in the current cycle counts as already captured so the decision loses no cycle.
    assign w_aw_hs   = s_awvalid & r_awready;
    assign w_w_hs    = s_wvalid & r_wready;
    assign w_ar_hs   = s_arvalid & r_arready;
    assign w_aw_v    = r_aw_q | w_aw_hs;
    assign w_w_v     = r_w_q | w_w_hs;
    assign w_ar_v    = r_ar_q | w_ar_hs;
    assign w_awaddr  = r_aw_q ? r_awaddr : s_awaddr;
    assign w_wdata   = r_w_q ? r_wdata : s_wdata;
    assign w_wstrb   = r_w_q ? r_wstrb : s_wstrb;
    assign w_araddr  = r_ar_q ? r_araddr : s_araddr;
    assign w_pick_wr = w_aw_v & w_w_v & (~w_ar_v | ~r_rr);
    assign w_pick_rd = w_ar_v & ~w_pick_wr;
    // Ack on the final timeout cycle still wins and yields OKAY.
    assign w_done    = wbm_ack_i | (r_cnt == TO_LAST);
    assign w_resp    = wbm_ack_i ? RESP_OKAY : RESP_SLVERR;

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_arready = r_arready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_rvalid  = r_rvalid;
    assign s_rresp   = r_rresp;
    assign s_rdata   = r_rdata;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_adr_o = r_adr;
    assign wbm_sel_o = r_sel;
    assign wbm_dat_o = r_dat;

    // Bridge FSM: capture, arbitration, Wishbone cycle with timeout, AXI response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_aw_q    <= 1'b0;
            r_w_q     <= 1'b0;
            r_ar_q    <= 1'b0;
            r_rr      <= 1'b0;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_adr     <= '0;
            r_wdata   <= '0;
            r_dat     <= '0;
            r_rdata   <= '0;
            r_wstrb   <= '0;
            r_sel     <= '0;
            r_cnt     <= 16'd0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) r_awaddr <= s_awaddr;
                    if (w_w_hs) begin
                        r_wdata <= s_wdata;
                        r_wstrb <= s_wstrb;
                    end
                    if (w_ar_hs) r_araddr <= s_araddr;
                    r_aw_q <= w_aw_v;
                    r_w_q  <= w_w_v;
                    r_ar_q <= w_ar_v;
                    if (w_pick_wr) begin
                        r_rr      <= 1'b1;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_arready <= 1'b0;
                        if (w_wstrb == '0) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= RESP_OKAY;
                            r_state  <= ST_B_RESP;
                        end else begin
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b1;
                            r_adr   <= w_awaddr;
                            r_sel   <= w_wstrb;
                            r_dat   <= w_wdata;
                            r_cnt   <= 16'd0;
                            r_state <= ST_WB_WR;
                        end
                    end else if (w_pick_rd) begin
                        r_rr      <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_arready <= 1'b0;
                        r_cyc     <= 1'b1;
                        r_we      <= 1'b0;
                        r_adr     <= w_araddr;
                        r_sel     <= '1;
                        r_cnt     <= 16'd0;
                        r_state   <= ST_WB_RD;
                    end else begin
                        r_awready <= ~w_aw_v;
                        r_wready  <= ~w_w_v;
                        r_arready <= ~w_ar_v;
                    end
                end
                ST_WB_WR, ST_WB_RD: begin
                    if (w_done) begin
                        r_cyc <= 1'b0;
                        if (r_state == ST_WB_RD) begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= w_resp;
                            r_rdata  <= wbm_ack_i ? wbm_dat_i : '0;
                            r_state  <= ST_R_RESP;
                        end else begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_resp;
                            r_state  <= ST_B_RESP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_B_RESP: begin
                    if (s_bready) begin
                        r_bvalid  <= 1'b0;
                        r_aw_q    <= 1'b0;
                        r_w_q     <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_arready <= ~r_ar_q;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_R_RESP: begin
                    if (s_rready) begin
                        r_rvalid  <= 1'b0;
                        r_ar_q    <= 1'b0;
                        r_awready <= ~r_aw_q;
                        r_wready  <= ~r_w_q;
                        r_arready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi2wb_bridge.sv
// Self-checking bench for axi2wb_bridge: Wishbone slave with byte memory, AXI-Lite drivers,
// and a word-level reference memory that predicts read data and bus traffic.
module tb_axi2wb_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;

    always #5 clk = ~clk;

    axi2wb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_txn_t;

    // Wishbone slave state: ack_at = cycle of cyc on which to ack (0 = never).
    int          ack_at = 1;
    int          cyc_run = 0, last_cyc_len = 0, cyc_starts = 0, ack_cyc = 0;
    bit          stray_ack = 1'b0;
    wb_txn_t     wb_log[$];
    wb_txn_t     s_t;
    logic [31:0] s_word;
    logic [31:0] smem   [logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = ref_read(a);
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[a] = w;
    endtask

    always @(posedge clk) cycle_cnt++;

    always @(posedge clk) begin
        #1;
        if (wbm_cyc_o === 1'b1) begin
            if (cyc_run == 0) cyc_starts++;
            cyc_run++;
            if (ack_at != 0 && cyc_run == ack_at) begin
                s_t.we = wbm_we_o; s_t.adr = wbm_adr_o; s_t.dat = wbm_dat_o; s_t.sel = wbm_sel_o;
                wb_log.push_back(s_t);
                s_word = smem.exists(wbm_adr_o) ? smem[wbm_adr_o] : dflt(wbm_adr_o);
                if (wbm_we_o) begin
                    s_word = (s_word & ~{{8{wbm_sel_o[3]}}, {8{wbm_sel_o[2]}}, {8{wbm_sel_o[1]}}, {8{wbm_sel_o[0]}}})
                           | (wbm_dat_o & {{8{wbm_sel_o[3]}}, {8{wbm_sel_o[2]}}, {8{wbm_sel_o[1]}}, {8{wbm_sel_o[0]}}});
                    smem[wbm_adr_o] = s_word;
                    wbm_dat_i = $urandom;
                end else begin
                    wbm_dat_i = s_word;
                end
                wbm_ack_i = 1'b1;
                ack_cyc = cycle_cnt;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
            end
        end else begin
            if (cyc_run != 0) last_cyc_len = cyc_run;
            cyc_run = 0;
            wbm_ack_i = stray_ack;
            wbm_dat_i = $urandom;
        end
    end

    // AXI write driver; w_lead = cycles W is presented before AW.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, output logic [1:0] resp, output int cap_cyc,
                             output int b_cyc, output bit to);
        int n, lead;
        bit aw_done, w_done, aw_f, w_f;
        to = 1'b0; aw_done = 1'b0; w_done = 1'b0; lead = w_lead;
        cap_cyc = 0; b_cyc = 0; resp = 2'b11; n = 0;
        @(negedge clk);
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        if (lead == 0) begin s_awaddr = a; s_awvalid = 1'b1; end
        while (!(aw_done && w_done) && n < 200) begin
            aw_f = s_awvalid && s_awready;
            w_f  = s_wvalid && s_wready;
            @(posedge clk); #1;
            if (aw_f) begin s_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_f) begin s_wvalid = 1'b0; w_done = 1'b1; end
            if (aw_f || w_f) cap_cyc = cycle_cnt;
            if (!aw_done && !s_awvalid) begin
                lead--;
                if (lead <= 0) begin s_awaddr = a; s_awvalid = 1'b1; end
            end
            @(negedge clk); n++;
        end
        if (n >= 200) begin to = 1'b1; s_awvalid = 1'b0; s_wvalid = 1'b0; return; end
        s_bready = 1'b1; n = 0;
        while (s_bvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin to = 1'b1; s_bready = 1'b0; return; end
        resp = s_bresp; b_cyc = cycle_cnt;
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    // AXI read driver; rready held low rdly cycles after rvalid, tracking response stability.
    task automatic axi_read(input logic [31:0] a, input int rdly, output logic [31:0] data,
                            output logic [1:0] resp, output bit stable, output bit to);
        int n;
        bit done, f;
        to = 1'b0; done = 1'b0; stable = 1'b1; data = '0; resp = 2'b11; n = 0;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1'b1;
        while (!done && n < 200) begin
            f = s_arready;
            @(posedge clk); #1;
            if (f) begin s_arvalid = 1'b0; done = 1'b1; end
            @(negedge clk); n++;
        end
        if (!done) begin to = 1'b1; s_arvalid = 1'b0; return; end
        n = 0;
        while (s_rvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin to = 1'b1; return; end
        data = s_rdata; resp = s_rresp;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            if (s_rvalid !== 1'b1 || s_rdata !== data || s_rresp !== resp || s_arready !== 1'b0) stable = 1'b0;
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
    endtask

    task automatic test_reset();
        int starts;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({s_awready, s_wready, s_arready} !== 3'b000) begin errors++; $display("FAIL rst_readies got %b expected 000", {s_awready, s_wready, s_arready}); end
        checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, s_bvalid, s_rvalid} !== 5'b0) begin errors++; $display("FAIL rst_ctrl got %b expected 00000", {wbm_cyc_o, wbm_stb_o, wbm_we_o, s_bvalid, s_rvalid}); end
        checks++; if ({s_bresp, s_rresp, s_rdata, wbm_adr_o, wbm_sel_o, wbm_dat_o} !== '0) begin errors++; $display("FAIL rst_data got nonzero bresp %b rresp %b rdata %h adr %h expected all 0", s_bresp, s_rresp, s_rdata, wbm_adr_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++; $display("FAIL idle_readies got %b expected 111", {s_awready, s_wready, s_arready}); end
        starts = cyc_starts;
        @(negedge clk); stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        stray_ack = 1'b0;
        checks++; if ({s_bvalid, s_rvalid, wbm_cyc_o} !== 3'b000 || cyc_starts != starts) begin errors++; $display("FAIL stray_ack got bvalid/rvalid/cyc %b starts %0d expected 000 starts %0d", {s_bvalid, s_rvalid, wbm_cyc_o}, cyc_starts, starts); end
    endtask

    task automatic test_write_basic();
        logic [1:0] resp; int cap, bc; bit to; wb_txn_t t;
        ack_at = 3; wb_log.delete();
        axi_write(32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 0, resp, cap, bc, to);
        ref_write(32'h3800_0010, 32'hDEAD_BEEF, 4'hF);
        checks++; if (to !== 1'b0 || wb_log.size() != 1) begin errors++; $display("FAIL wr_basic_count got to=%0d txns=%0d expected to=0 txns=1", to, wb_log.size()); end
        if (wb_log.size() != 0) begin
            t = wb_log.pop_front();
            checks++; if ({t.we, t.adr, t.dat, t.sel} !== {1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF}) begin errors++; $display("FAIL wr_basic_bus got we %b adr %h dat %h sel %h expected 1 38000010 deadbeef f", t.we, t.adr, t.dat, t.sel); end
        end
        checks++; if (resp !== 2'b00) begin errors++; $display("FAIL wr_basic_bresp got %b expected 00", resp); end
        checks++; if (bc != ack_cyc + 1) begin errors++; $display("FAIL wr_basic_blat got cycle %0d expected %0d", bc, ack_cyc + 1); end
        checks++; if (last_cyc_len != 3) begin errors++; $display("FAIL wr_basic_cyclen got %0d expected 3", last_cyc_len); end
    endtask

    task automatic test_min_latency();
        logic [1:0] resp; int cap, bc; bit to; logic [31:0] d;
        ack_at = 1; wb_log.delete(); d = $urandom;
        axi_write(32'h3800_0020, d, 4'hF, 0, resp, cap, bc, to);
        ref_write(32'h3800_0020, d, 4'hF);
        checks++; if (to !== 1'b0 || bc != cap + 1 || resp !== 2'b00) begin errors++; $display("FAIL min_lat got to=%0d b_cycle %0d resp %b expected 0 %0d 00", to, bc, resp, cap + 1); end
        checks++; if (last_cyc_len != 1) begin errors++; $display("FAIL min_lat_cyclen got %0d expected 1", last_cyc_len); end
    endtask

    task automatic test_read_backpressure();
        logic [31:0] d; logic [1:0] resp; bit st, to; wb_txn_t t;
        smem[32'h3010_0004] = 32'h1234_5678; ref_mem[32'h3010_0004] = 32'h1234_5678;
        ack_at = 2; wb_log.delete();
        axi_read(32'h3010_0004, 5, d, resp, st, to);
        checks++; if (to !== 1'b0 || d !== 32'h1234_5678 || resp !== 2'b00) begin errors++; $display("FAIL rd_bp_data got to=%0d rdata %h rresp %b expected 0 12345678 00", to, d, resp); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL rd_bp_stable got %0d expected 1", st); end
        checks++; if (wb_log.size() != 1) begin errors++; $display("FAIL rd_bp_count got %0d expected 1", wb_log.size()); end
        if (wb_log.size() != 0) begin
            t = wb_log.pop_front();
            checks++; if ({t.we, t.adr} !== {1'b0, 32'h3010_0004}) begin errors++; $display("FAIL rd_bp_bus got we %b adr %h expected 0 30100004", t.we, t.adr); end
        end
    endtask

    task automatic test_wstrb_zero();
        logic [1:0] resp; int cap, bc, starts; bit to;
        wb_log.delete(); starts = cyc_starts;
        axi_write(32'h3800_0010, 32'hFFFF_FFFF, 4'h0, 4, resp, cap, bc, to);
        checks++; if (to !== 1'b0 || resp !== 2'b00) begin errors++; $display("FAIL strb0_bresp got to=%0d resp %b expected 0 00", to, resp); end
        checks++; if (cyc_starts != starts || wb_log.size() != 0) begin errors++; $display("FAIL strb0_nocyc got starts %0d txns %0d expected %0d 0", cyc_starts, wb_log.size(), starts); end
    endtask

    task automatic test_arbitration();
        logic [31:0] rd, wa, ra, wd; bit gb, gr, awf, wf, arf, bf, rf; int n;
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        ack_at = 1; wb_log.delete();
        for (int k = 0; k < 4; k++) begin
            wa = 32'h3800_0040 + 32'(4 * k); ra = 32'h3800_0080 + 32'(4 * k); wd = $urandom;
            @(negedge clk);
            s_awaddr = wa; s_wdata = wd; s_wstrb = 4'hF; s_araddr = ra;
            s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
            gb = 1'b0; gr = 1'b0; n = 0; rd = '0;
            while (!(gb && gr) && n < 100) begin
                awf = s_awvalid && s_awready; wf = s_wvalid && s_wready; arf = s_arvalid && s_arready;
                bf = s_bvalid; rf = s_rvalid;
                if (rf) rd = s_rdata;
                @(posedge clk); #1;
                if (awf) s_awvalid = 1'b0;
                if (wf) s_wvalid = 1'b0;
                if (arf) s_arvalid = 1'b0;
                if (bf) gb = 1'b1;
                if (rf) gr = 1'b1;
                @(negedge clk); n++;
            end
            s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
            checks++; if (!(gb && gr) || rd !== ref_read(ra)) begin errors++; $display("FAIL arb_round%0d got b=%0d r=%0d rdata %h expected 1 1 %h", k, gb, gr, rd, ref_read(ra)); end
            ref_write(wa, wd, 4'hF);
        end
        checks++; if (wb_log.size() != 8) begin errors++; $display("FAIL arb_count got %0d expected 8", wb_log.size()); end
        for (int i = 0; i < 8 && wb_log.size() != 0; i++) begin
            wb_txn_t t;
            t = wb_log.pop_front();
            checks++; if (t.we !== ((i % 2) == 0)) begin errors++; $display("FAIL arb_order%0d got we %b expected %0d", i, t.we, (i % 2) == 0); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic [1:0] resp; bit st, to; int cap, bc;
        ack_at = 0; wb_log.delete();
        axi_read(32'h3800_0040, 0, d, resp, st, to);
        checks++; if (to !== 1'b0 || resp !== 2'b10 || d !== 32'h0) begin errors++; $display("FAIL to_rd got to=%0d rresp %b rdata %h expected 0 10 00000000", to, resp, d); end
        checks++; if (last_cyc_len != TO) begin errors++; $display("FAIL to_rd_cyclen got %0d expected %0d", last_cyc_len, TO); end
        axi_write(32'h3800_0044, 32'h0BAD_F00D, 4'hF, 0, resp, cap, bc, to);
        checks++; if (to !== 1'b0 || resp !== 2'b10 || last_cyc_len != TO) begin errors++; $display("FAIL to_wr got to=%0d bresp %b cyclen %0d expected 0 10 %0d", to, resp, last_cyc_len, TO); end
        ack_at = TO;
        axi_read(32'h3800_0044, 0, d, resp, st, to);
        checks++; if (to !== 1'b0 || resp !== 2'b00 || d !== ref_read(32'h3800_0044)) begin errors++; $display("FAIL to_lastack got to=%0d rresp %b rdata %h expected 0 00 %h", to, resp, d, ref_read(32'h3800_0044)); end
    endtask

    task automatic test_reset_midread();
        int n, starts; bit seen_rv; logic [31:0] d; logic [1:0] resp; bit st, to;
        ack_at = 0; wb_log.delete();
        @(negedge clk); s_araddr = 32'h3800_0048; s_arvalid = 1'b1; n = 0;
        while (s_arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1; s_arvalid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (wbm_cyc_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre got cyc %b expected 1", wbm_cyc_o); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({wbm_cyc_o, s_rvalid, s_awready, s_wready, s_arready} !== 5'b0) begin errors++; $display("FAIL rstmid_abort got cyc/rvalid/readies %b expected 00000", {wbm_cyc_o, s_rvalid, s_awready, s_wready, s_arready}); end
        @(negedge clk); rst = 1'b0; starts = cyc_starts; seen_rv = 1'b0;
        repeat (12) begin @(negedge clk); if (s_rvalid !== 1'b0) seen_rv = 1'b1; end
        checks++; if (seen_rv || cyc_starts != starts) begin errors++; $display("FAIL rstmid_quiet got rvalid_seen %0d starts %0d expected 0 %0d", seen_rv, cyc_starts, starts); end
        checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++; $display("FAIL rstmid_idle got %b expected 111", {s_awready, s_wready, s_arready}); end
        ack_at = 1;
        axi_read(32'h3800_0048, 0, d, resp, st, to);
        checks++; if (to !== 1'b0 || resp !== 2'b00 || d !== ref_read(32'h3800_0048)) begin errors++; $display("FAIL rstmid_after got to=%0d rresp %b rdata %h expected 0 00 %h", to, resp, d, ref_read(32'h3800_0048)); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd; logic [3:0] s; logic [1:0] resp; bit st, to; int cap, bc; wb_txn_t t;
        for (int i = 0; i < 30; i++) begin
            a = 32'h3800_0000 + 32'(4 * $urandom_range(0, 3));
            ack_at = $urandom_range(1, 4);
            wb_log.delete();
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 2), resp, cap, bc, to);
                ref_write(a, d, s);
                checks++; if (to !== 1'b0 || resp !== 2'b00 || wb_log.size() != ((s != 4'h0) ? 1 : 0)) begin errors++; $display("FAIL rnd_wr%0d got to=%0d resp %b txns %0d strb %h", i, to, resp, wb_log.size(), s); end
                if (wb_log.size() != 0) begin
                    t = wb_log.pop_front();
                    checks++; if ({t.we, t.adr, t.dat, t.sel} !== {1'b1, a, d, s}) begin errors++; $display("FAIL rnd_wrbus%0d got %b %h %h %h expected 1 %h %h %h", i, t.we, t.adr, t.dat, t.sel, a, d, s); end
                end
            end else begin
                axi_read(a, $urandom_range(0, 2), rd, resp, st, to);
                checks++; if (to !== 1'b0 || resp !== 2'b00 || rd !== ref_read(a) || st !== 1'b1) begin errors++; $display("FAIL rnd_rd%0d got to=%0d resp %b rdata %h stable %0d expected 0 00 %h 1", i, to, resp, rd, st, ref_read(a)); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        wbm_ack_i = 1'b0; wbm_dat_i = '0;
        test_reset();
        test_write_basic();
        test_min_latency();
        test_read_backpressure();
        test_wstrb_zero();
        test_arbitration();
        test_timeout();
        test_reset_midread();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cycle_cnt);
        $fatal(1, "watchdog");
    end

endmodule
